// File: rtl/spoc_postproc_pkg.sv
// spoc_postproc_pkg -- shared constants for the SPoC output post-processor.
//
// Holds the FSM state encodings, LWC segment header type codes, status
// words, tag geometry and a helper that builds a segment header word.
// Imported by spoc_postproc.

package spoc_postproc_pkg;

  // FSM state encodings (plain constants so the state register stays a
  // simple logic vector).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MSG_HDR   = 3'd1;
  localparam logic [2:0] ST_MSG_DATA  = 3'd2;
  localparam logic [2:0] ST_TAG_HDR   = 3'd3;
  localparam logic [2:0] ST_TAG_DATA  = 3'd4;
  localparam logic [2:0] ST_WAIT_AUTH = 3'd5;
  localparam logic [2:0] ST_STATUS    = 3'd6;

  // Segment header type codes.
  localparam logic [3:0] HDR_MSG = 4'b0100;
  localparam logic [3:0] HDR_TAG = 4'b1000;

  // Status words: success covers encryption and a matching tag.
  localparam logic [31:0] STATUS_SUCCESS = 32'hE000_0000;
  localparam logic [31:0] STATUS_FAILURE = 32'hF000_0000;

  // Tag geometry.
  localparam int          TAG_WORDS = 2;
  localparam logic [15:0] TAG_BYTES = 16'd8;

  // Segment header: {type, 2'b00, eot=1, last, 8'h00, len}.
  function automatic logic [31:0] seg_hdr(input logic [3:0]  seg_type,
                                          input logic        last,
                                          input logic [15:0] len);
    return {seg_type, 1'b0, 1'b0, 1'b1, last, 8'h00, len};
  endfunction

endpackage

// File: rtl/spoc_pp_bytemask.sv
// spoc_pp_bytemask -- combinational byte masking and valid-byte count for a
// big-endian 32-bit cipher output word.
//
// Ports:
//   data        in  32  cipher output word, byte 3 = data[31:24]
//   valid_bytes in  4   per-byte valid flags, bit i qualifies data[8i+7:8i]
//   data_out    out 32  word with invalid bytes zeroed (masking build) or
//                       data unchanged (default build)
//   byte_count  out 3   number of set bits in valid_bytes
//
// Configuration: define SPOC_POSTPROC_MASK_EN to zero invalid bytes.

module spoc_pp_bytemask (
  input  logic [31:0] data,
  input  logic [3:0]  valid_bytes,
  output logic [31:0] data_out,
  output logic [2:0]  byte_count
);

  always_comb begin
    byte_count = '0;
    for (int i = 0; i < 4; i++) begin
      byte_count = byte_count + {2'b00, valid_bytes[i]};
    end
  end

`ifdef SPOC_POSTPROC_MASK_EN
  always_comb begin
    data_out = '0;
    for (int i = 0; i < 4; i++) begin
      data_out[8*i +: 8] = valid_bytes[i] ? data[8*i +: 8] : 8'h00;
    end
  end
`else
  assign data_out = data;
`endif

endmodule

// File: rtl/spoc_postproc.sv
// spoc_postproc -- SPoC cipher output post-processor. Wraps the raw cipher
// word stream into LWC output segments: optional MSG header + data, then
// either TAG header + tag words (encrypt) or a tag-compare wait (decrypt),
// and finally a status word flagged with do_last.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   op_valid/op_ready             operation descriptor handshake
//   op_decrypt, op_len[15:0]      1 = decrypt; message byte count
//   bdo[31:0], bdo_valid,
//   bdo_ready, bdo_valid_bytes[3:0]  cipher output words (big-endian bytes)
//   msg_auth, msg_auth_valid,
//   msg_auth_ready                tag-compare result
//   do_data[31:0], do_valid,
//   do_ready, do_last             LWC output stream
//
// Configuration: define SPOC_POSTPROC_MASK_EN to zero invalid message bytes.

module spoc_postproc
  import spoc_postproc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_decrypt,
  input  logic [15:0] op_len,
  input  logic [31:0] bdo,
  input  logic        bdo_valid,
  output logic        bdo_ready,
  input  logic [3:0]  bdo_valid_bytes,
  input  logic        msg_auth,
  input  logic        msg_auth_valid,
  output logic        msg_auth_ready,
  output logic [31:0] do_data,
  output logic        do_valid,
  input  logic        do_ready,
  output logic        do_last
);

  logic [2:0]  state, state_nxt;
  logic [16:0] rem_bytes;
  logic [16:0] rem_after;
  logic [1:0]  tag_cnt;
  logic        decrypt_q;
  logic        auth_q;
  logic [31:0] bdo_masked;
  logic [2:0]  bdo_bytes;
  logic        word_xfer;
  logic [2:0]  post_msg_state;

  spoc_pp_bytemask u_bytemask (
    .data        (bdo),
    .valid_bytes (bdo_valid_bytes),
    .data_out    (bdo_masked),
    .byte_count  (bdo_bytes)
  );

  // A word moves only when both sides are ready; bdo_ready mirrors do_ready
  // in the data states so no word is taken without being delivered.
  assign word_xfer = bdo_valid & do_ready;

  // Saturating decrement: an over-full final word must not wrap the counter.
  assign rem_after = (rem_bytes > {14'd0, bdo_bytes})
                   ? rem_bytes - {14'd0, bdo_bytes} : '0;

  assign post_msg_state = decrypt_q ? ST_WAIT_AUTH : ST_TAG_HDR;

  // NOTE: every output and next-state signal gets a default before the case
  // so the combinational block never infers a latch.
  always_comb begin
    state_nxt      = state;
    op_ready       = 1'b0;
    bdo_ready      = 1'b0;
    msg_auth_ready = 1'b0;
    do_valid       = 1'b0;
    do_last        = 1'b0;
    do_data        = '0;
    case (state)
      ST_IDLE: begin
        // Gated with rst so nothing is advertised while reset is held.
        op_ready = rst;
        if (op_valid) begin
          if (op_len != 16'd0) state_nxt = ST_MSG_HDR;
          else if (op_decrypt) state_nxt = ST_WAIT_AUTH;
          else                 state_nxt = ST_TAG_HDR;
        end
      end
      ST_MSG_HDR: begin
        do_valid = 1'b1;
        // rem_bytes still holds op_len here; no word has been counted yet.
        do_data  = seg_hdr(HDR_MSG, decrypt_q, rem_bytes[15:0]);
        if (do_ready) state_nxt = ST_MSG_DATA;
      end
      ST_MSG_DATA: begin
        bdo_ready = do_ready;
        do_valid  = bdo_valid;
        do_data   = bdo_masked;
        if (word_xfer && rem_after == '0) state_nxt = post_msg_state;
      end
      ST_TAG_HDR: begin
        do_valid = 1'b1;
        do_data  = seg_hdr(HDR_TAG, 1'b1, TAG_BYTES);
        if (do_ready) state_nxt = ST_TAG_DATA;
      end
      ST_TAG_DATA: begin
        bdo_ready = do_ready;
        do_valid  = bdo_valid;
        do_data   = bdo;
        if (word_xfer && tag_cnt == 2'(TAG_WORDS - 1)) state_nxt = ST_STATUS;
      end
      ST_WAIT_AUTH: begin
        msg_auth_ready = 1'b1;
        if (msg_auth_valid) state_nxt = ST_STATUS;
      end
      ST_STATUS: begin
        do_valid = 1'b1;
        do_last  = 1'b1;
        do_data  = (decrypt_q && !auth_q) ? STATUS_FAILURE : STATUS_SUCCESS;
        if (do_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rem_bytes <= '0;
      tag_cnt   <= '0;
      decrypt_q <= 1'b0;
      auth_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            decrypt_q <= op_decrypt;
            auth_q    <= 1'b0;
            rem_bytes <= {1'b0, op_len};
          end
        end
        ST_MSG_DATA: if (word_xfer) rem_bytes <= rem_after;
        ST_TAG_HDR:  tag_cnt <= '0;
        ST_TAG_DATA: if (word_xfer) tag_cnt <= tag_cnt + 2'd1;
        ST_WAIT_AUTH: if (msg_auth_valid) auth_q <= msg_auth;
        default: ;
      endcase
    end
  end

endmodule
